// File: rtl/mmio_uart_tx.sv
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped debug console transmitter. Stores to TX_ADDR
//                push a byte into a FIFO. A serialiser drains the FIFO onto
//                the tx pin, one start bit, eight data bits LSB first and one
//                stop bit. A status register at TX_ADDR+4 lets firmware poll
//                the FIFO before it stores.
//  Config      : Define UART_TX_PARITY_EN to insert an even-parity bit between
//                the data bits and the stop bit, giving an 11-bit frame.
//  Ports       : clk        system clock
//                rst        synchronous active-high reset
//                mem_addr   data-port byte address
//                mem_wdata  store data ([7:0] = byte, [3] on STATUS = clear)
//                mem_we     store strobe, one cycle per store
//                mem_re     load strobe
//                rdata      registered load data, valid the cycle after mem_re
//                tx         UART serial output, idle high
//                busy       serialiser is mid-frame
//                overflow   sticky flag, a store was dropped on a full FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_uart_tx #(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] TX_ADDR    = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int c_DIV   = CLK_HZ / BAUD;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMR_W = $clog2(c_DIV);

    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]        c_STAT_ADDR = TX_ADDR + 32'd4;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd4;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic [31:0]        r_rdata;
    logic               r_tx;
    logic [2:0]         r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_full;
    logic               w_empty;
    logic               w_busy;
    logic               w_tx_sel;
    logic               w_st_sel;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_tmr_done;
    logic [2:0]         w_state_next;
    logic [c_TMR_W-1:0] w_tmr_next;
    logic [2:0]         w_bit_next;
    logic [7:0]         w_shift_next;
    logic               w_tx_next;
    logic [c_CNT_W-1:0] w_count_next;
    logic [31:0]        w_status;
    logic               w_unused;

    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_busy   = (r_state != c_S_IDLE);
    assign w_tx_sel = (mem_addr == TX_ADDR);
    assign w_st_sel = (mem_addr == c_STAT_ADDR);

    // Fullness is judged on the current count, so a store that arrives
    // while full is dropped even if the serialiser pops in the same cycle.
    assign w_push = mem_we && w_tx_sel && !w_full;
    assign w_drop = mem_we && w_tx_sel && w_full;

    assign w_status = {16'b0, 8'(r_count), 4'b0, r_ovf, w_full, w_empty, w_busy};

    // Only the low byte and the clear bit of the store data are meaningful.
    assign w_unused = ^mem_wdata[31:8];

    // ------------------------------------------------------------------
    // Serialiser next-state logic
    // ------------------------------------------------------------------
    assign w_tmr_done = (r_tmr == c_TMR_LAST);

    always_comb begin
        w_state_next = r_state;
        w_tmr_next   = r_tmr;
        w_bit_next   = r_bit;
        w_pop        = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_tmr_next = '0;
                w_bit_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = c_S_START;
                end
            end
            c_S_START: begin
                if (w_tmr_done) begin
                    w_tmr_next   = '0;
                    w_state_next = c_S_DATA;
                end else begin
                    w_tmr_next = r_tmr + c_TMR_W'(1);
                end
            end
            c_S_DATA: begin
                if (w_tmr_done) begin
                    w_tmr_next = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = c_S_PARITY;
`else
                        w_state_next = c_S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_tmr_next = r_tmr + c_TMR_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            c_S_PARITY: begin
                if (w_tmr_done) begin
                    w_tmr_next   = '0;
                    w_state_next = c_S_STOP;
                end else begin
                    w_tmr_next = r_tmr + c_TMR_W'(1);
                end
            end
`endif
            c_S_STOP: begin
                if (w_tmr_done) begin
                    w_tmr_next   = '0;
                    w_state_next = c_S_IDLE;
                end else begin
                    w_tmr_next = r_tmr + c_TMR_W'(1);
                end
            end
            default: begin
                w_tmr_next   = '0;
                w_bit_next   = '0;
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    assign w_shift_next = w_pop ? r_mem[r_rptr] : r_shift;

    // tx is registered from the level the *next* state will drive, so the
    // pin changes exactly on the state transition with no decode glitches.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            c_S_START:  w_tx_next = 1'b0;
            c_S_DATA:   w_tx_next = w_shift_next[w_bit_next];
`ifdef UART_TX_PARITY_EN
            c_S_PARITY: w_tx_next = ^r_shift;
`endif
            default:    w_tx_next = 1'b1;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_tmr   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_tmr   <= w_tmr_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            // A dropped store in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (mem_we && w_st_sel && mem_wdata[3]) begin
                r_ovf <= 1'b0;
            end
            r_rdata <= (mem_re && w_st_sel) ? w_status : 32'd0;
        end
    end

    // FIFO storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= mem_wdata[7:0];
        end
    end

    assign rdata    = r_rdata;
    assign tx       = r_tx;
    assign busy     = w_busy;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Directed self-checking bench for mmio_uart_tx with
//                CLK_HZ=16, BAUD=4 (4 cycles per bit) and an 8-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_uart_tx;

    localparam int          c_DIV       = 4;
    localparam logic [31:0] c_TX_ADDR   = 32'hFFFF_0000;
    localparam logic [31:0] c_STAT_ADDR = 32'hFFFF_0004;
`ifdef UART_TX_PARITY_EN
    localparam int          c_NBITS     = 11;
`else
    localparam int          c_NBITS     = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_uart_tx #(
        .CLK_HZ     (16),
        .BAUD       (4),
        .FIFO_DEPTH (8),
        .TX_ADDR    (c_TX_ADDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .rdata     (rdata),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // One cycle: inputs change and outputs are sampled 1 time unit after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        step();
        mem_we    = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr);
        mem_re   = 1'b1;
        mem_addr = addr;
        step();
        mem_re   = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %b expected %b", name, obs, exp);
        else n_pass++;
    endtask

    task automatic check_word(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
        else n_pass++;
    endtask

    // Entered on the first cycle of the start bit; leaves on the idle
    // cycle that follows the stop bit. One comparison per frame bit.
    task automatic frame_check(input logic [7:0] b, input string name);
        logic exp;
        logic ok;
        logic bad_tx;
        logic bad_busy;
        for (int k = 0; k < c_NBITS; k++) begin
            if (k == 0) exp = 1'b0;
            else if (k <= 8) exp = b[k-1];
`ifdef UART_TX_PARITY_EN
            else if (k == 9) exp = ^b;
`endif
            else exp = 1'b1;
            ok = 1'b1;
            bad_tx = exp;
            bad_busy = 1'b1;
            for (int c = 0; c < c_DIV; c++) begin
                if (tx !== exp || busy !== 1'b1) begin
                    ok = 1'b0;
                    bad_tx = tx;
                    bad_busy = busy;
                end
                step();
            end
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL %s frame bit %0d: tx=%b busy=%b expected tx=%b busy=1",
                          name, k, bad_tx, bad_busy, exp);
        end
    endtask

    task automatic wait_start(input int max_cycles, input string name);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < max_cycles) begin
            step();
            n++;
        end
        n_checks++;
        if (tx !== 1'b0) $display("FAIL %s start bit timeout: tx=%b expected 0", name, tx);
        else n_pass++;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        int n;
        int idle_run;
        n = 0;
        idle_run = 0;
        while (idle_run < 3 && n < max_cycles) begin
            if (busy === 1'b0) idle_run++;
            else idle_run = 0;
            step();
            n++;
        end
        n_checks++;
        if (idle_run < 3) $display("FAIL %s drain timeout: busy=%b expected 0", name, busy);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_bit("reset tx", tx, 1'b1);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset overflow", overflow, 1'b0);
        check_word("reset rdata", rdata, 32'h0);
        step();
        check_bit("reset stays idle", busy, 1'b0);
    endtask

    task automatic test_single_frame();
        do_store(c_TX_ADDR, 32'h41);
        check_bit("single N+1 tx", tx, 1'b1);
        check_bit("single N+1 busy", busy, 1'b0);
        step();
        frame_check(8'h41, "single 0x41");
        check_bit("single end busy", busy, 1'b0);
        check_bit("single end tx", tx, 1'b1);
    endtask

    task automatic test_overflow();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    mem_we    = 1'b1;
                    mem_addr  = c_TX_ADDR;
                    mem_wdata = 32'h30 + i;
                    step();
                end
                mem_we = 1'b0;
                check_bit("overflow set", overflow, 1'b1);
                do_load(c_STAT_ADDR);
                check_word("status full", rdata, 32'h0000_080D);
            end
            begin
                step();
                step();
                frame_check(8'h30, "burst byte0");
            end
        join
        for (int k = 1; k < 9; k++) begin
            check_bit("burst gap tx", tx, 1'b1);
            check_bit("burst gap busy", busy, 1'b0);
            step();
            frame_check(8'h30 + 8'(k), "burst");
        end
        step();
        check_bit("burst nothing after", busy, 1'b0);
        check_bit("overflow sticky", overflow, 1'b1);
        do_store(c_STAT_ADDR, 32'h0000_0008);
        check_bit("overflow cleared", overflow, 1'b0);
    endtask

    task automatic test_status();
        do_load(c_STAT_ADDR);
        check_word("status idle", rdata, 32'h0000_0002);
        step();
        check_word("rdata no load", rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            mem_we    = 1'b1;
            mem_addr  = c_TX_ADDR;
            mem_wdata = 32'hA5 + i;
            step();
        end
        mem_we = 1'b0;
        do_load(c_STAT_ADDR);
        check_word("status 3 queued", rdata, 32'h0000_0301);
        do_load(c_TX_ADDR);
        check_word("load TX_ADDR", rdata, 32'h0);
        do_load(32'h0000_1000);
        check_word("load unmapped", rdata, 32'h0);
        wait_drain(4 * 41 + 20, "status drain");
    endtask

    task automatic test_data_patterns();
        do_store(c_TX_ADDR, 32'h1234_5655);
        wait_start(3, "pattern 0x55");
        frame_check(8'h55, "pattern 0x55");
        do_store(c_TX_ADDR, 32'h00);
        do_store(c_TX_ADDR, 32'hFF);
        wait_start(3, "pattern 0x00");
        frame_check(8'h00, "pattern 0x00");
        check_bit("pattern gap", tx, 1'b1);
        step();
        frame_check(8'hFF, "pattern 0xFF");
        check_bit("pattern end busy", busy, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic stayed;
        for (int i = 0; i < 5; i++) begin
            mem_we    = 1'b1;
            mem_addr  = c_TX_ADDR;
            mem_wdata = 32'h00 + i;
            step();
        end
        mem_we = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_bit("midframe tx low", tx, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_bit("abort tx", tx, 1'b1);
        check_bit("abort busy", busy, 1'b0);
        do_load(c_STAT_ADDR);
        check_word("abort status", rdata, 32'h0000_0002);
        stayed = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
            step();
        end
        check_bit("no frames after abort", stayed, 1'b1);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        do_store(c_TX_ADDR, 32'h41);
        step();
        frame_check(8'h41, "parity 0x41");
        check_bit("parity 44 cycles busy", busy, 1'b0);
        do_store(c_TX_ADDR, 32'h07);
        step();
        frame_check(8'h07, "parity 0x07");
        check_bit("parity 0x07 end busy", busy, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_status();
        test_data_patterns();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
